// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Optional timeout feature is controlled by the FIFO_RD_TIMEOUT_EN macro.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry registered output buffer; the head entry drives the stream outputs.
// Push and pop in the same cycle keep the occupancy unchanged.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             push_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } entry_t;

    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           new_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    assign out_valid = (cnt_q != '0);
    assign out_data  = head_q.data;
    assign out_last  = head_q.last;
    assign count     = cnt_q;
    assign pop       = out_valid && out_ready;
    assign new_entry = '{data: push_data, last: push_last};

    // The producer never pushes while both entries are occupied.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) head_d = new_entry;
                else             tail_d = new_entry;
                cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - CNT_W'(1);
            end
            2'b11: begin
                if (cnt_q == CNT_W'(1)) begin
                    head_d = new_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains N words from a show-ahead FIFO read port onto a valid/ready stream.
// Define FIFO_RD_TIMEOUT_EN to abort bursts that stall on an empty FIFO.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output state_e           dbg_state,
    output logic [CNT_W-1:0] dbg_buf_cnt
);

    // Stream handshake: a word transfers on a rising edge where m_valid and
    // m_ready are both high; m_data/m_last stay stable while m_valid waits.
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] buf_cnt;

    assign busy        = (state_q != IDLE);
    assign req_ready   = (state_q == IDLE);
    assign done        = done_q;
    assign dbg_state   = state_q;
    assign dbg_buf_cnt = buf_cnt;
    assign fifo_rinc   = (state_q == BURST) && !fifo_rempty
                         && (buf_cnt < CNT_W'(BUF_DEPTH)) && (rem_q != '0);

    fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (fifo_rinc),
        .push_data (fifo_rdata),
        .push_last (rem_q == LEN_W'(1)),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .count     (buf_cnt)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
    logic               err_q, err_d;
    logic               timeout_hit;

    // Any cycle that is not an empty-stall in BURST clears the counter.
    always_comb begin
        stall_d     = '0;
        timeout_hit = 1'b0;
        if (state_q == BURST && rem_q != '0 && fifo_rempty) begin
            stall_d     = stall_q + STALL_W'(1);
            timeout_hit = (stall_q == STALL_W'(TIMEOUT_CYC - 1));
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
        abort_d = abort_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = req_len;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (fifo_rinc) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DRAIN;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                if (timeout_hit) begin
                    rem_d   = '0;
                    state_d = DRAIN;
                    abort_d = 1'b1;
                end
`endif
            end
            DRAIN: begin
`ifdef FIFO_RD_TIMEOUT_EN
                // Aborted bursts carry no last-tagged word; finish once empty.
                if (abort_q) begin
                    if (buf_cnt == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        abort_d = 1'b0;
                    end
                end else
`endif
                if (m_valid && m_ready && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q <= stall_d;
            abort_q <= abort_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a show-ahead FIFO model and scoreboard.
// Runs the timeout scenario when FIFO_RD_TIMEOUT_EN is defined.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int DSIZE       = 8;
    localparam int LEN_W       = 8;
    localparam int TIMEOUT_CYC = 8;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_GAP = 4;
`else
    localparam int STALL_GAP = 20;
`endif

    logic             rclk;
    logic             rrst;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] req_len;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             err;
    state_e           dbg_state;
    logic [CNT_W-1:0] dbg_buf_cnt;

    fifo_burst_reader #(
        .DSIZE       (DSIZE),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_len     (req_len),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state   (dbg_state),
        .dbg_buf_cnt (dbg_buf_cnt)
    );

    // ---------------- clock ----------------
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // ---------------- show-ahead FIFO model ----------------
    logic [DSIZE-1:0] mem [0:63];
    int wptr = 0;
    int rptr = 0;

    assign fifo_rempty = (rptr == wptr);
    assign fifo_rdata  = mem[rptr];

    always @(posedge rclk) begin
        if (fifo_rinc && !fifo_rempty) rptr <= rptr + 1;
    end

    // ---------------- monitor ----------------
    logic [DSIZE:0] got_q[$];
    int             beat_cyc_q[$];
    int cyc = 0, pops = 0, pop_empty = 0, mvalid_cnt = 0;
    int done_cnt = 0, err_cnt = 0, last_done_cyc = 0;
    int hold_err = 0, cnt_err = 0, pair_err = 0;
    logic           hold_pend = 1'b0;
    logic [DSIZE:0] hold_word = '0;

    always @(negedge rclk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            got_q.push_back({m_last, m_data});
            beat_cyc_q.push_back(cyc);
        end
        if (fifo_rinc) pops <= pops + 1;
        if (fifo_rinc && fifo_rempty) pop_empty <= pop_empty + 1;
        if (m_valid) mvalid_cnt <= mvalid_cnt + 1;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (err && !done) pair_err <= pair_err + 1;
        if ((dbg_buf_cnt > CNT_W'(2)) || (fifo_rinc && dbg_buf_cnt == CNT_W'(2)))
            cnt_err <= cnt_err + 1;
        if (rrst) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && (!m_valid || {m_last, m_data} != hold_word))
                hold_err <= hold_err + 1;
            hold_pend <= m_valid && !m_ready;
            hold_word <= {m_last, m_data};
        end
    end

    // ---------------- scoreboard / checking ----------------
    logic [DSIZE:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beats(input string tag, input int base);
        check({tag, "_beats"}, got_q.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < got_q.size())
                check($sformatf("%s_beat%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic fifo_push(input logic [DSIZE-1:0] d);
        mem[wptr] = d;
        wptr++;
    endtask

    task automatic send_req(input int len);
        int n = 0;
        bit hs = 1'b0;
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        while (!hs && n < 20) begin
            hs = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("req_accept", 32'(hs), 1);
    endtask

    function automatic logic ready_pat(input int n);
        return (n % 4 == 0) || (n % 4 == 3);
    endfunction

    task automatic wait_done(input int start, input int budget, input bit toggle);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            if (toggle) m_ready = ready_pat(n);
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("done_seen", done_cnt - start, 1);
    endtask

    // ---------------- stimulus ----------------
    int base, p0, d0, e0, mv0, h0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rrst      = 1'b1;
        req_valid = 1'b0;
        req_len   = '0;
        m_ready   = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rinc", 32'(fifo_rinc), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rrst = 1'b0;
        tick();

        // T1: four words, m_ready held high
        base = got_q.size(); p0 = pops; d0 = done_cnt;
        for (int i = 0; i < 4; i++) fifo_push(DSIZE'(8'h11 + i));
        tick();
        send_req(4);
        wait_done(d0, 40, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), DSIZE'(8'h11 + i)});
        check("t1_pops", pops - p0, 4);
        if (beat_cyc_q.size() >= base + 4) begin
            check("t1_beat_span", beat_cyc_q[base + 3] - beat_cyc_q[base], 3);
            check("t1_done_latency", last_done_cyc - beat_cyc_q[base + 3], 1);
        end
        check_beats("t1", base);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_busy_low", 32'(busy), 0);

        // T2: same words with m_ready toggling 1,0,0,1
        base = got_q.size(); p0 = pops; d0 = done_cnt; h0 = hold_err;
        for (int i = 0; i < 4; i++) fifo_push(DSIZE'(8'h11 + i));
        tick();
        send_req(4);
        wait_done(d0, 80, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), DSIZE'(8'h11 + i)});
        check_beats("t2", base);
        check("t2_pops", pops - p0, 4);
        check("t2_hold_stable", hold_err - h0, 0);
        check("t2_bufcnt_rule", cnt_err, 0);

        // T3: zero-length request
        base = got_q.size(); p0 = pops; d0 = done_cnt; mv0 = mvalid_cnt;
        send_req(0);
        tick();
        tick();
        tick();
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_pops", pops - p0, 0);
        check("t3_m_valid", mvalid_cnt - mv0, 0);
        check("t3_busy_low", 32'(busy), 0);
        check_beats("t3", base);

        // T4: starved burst resumes when data arrives
        base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
        fifo_push(8'h21);
        tick();
        send_req(3);
        for (int i = 0; i < STALL_GAP + 4; i++) begin
            if (i == STALL_GAP)     fifo_push(8'h22);
            if (i == STALL_GAP + 3) fifo_push(8'h23);
            tick();
        end
        check("t4_busy_midway", 32'(busy), 1);
        wait_done(d0, 40, 1'b0);
        tick();
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h23});
        check_beats("t4", base);
        check("t4_err", err_cnt - e0, 0);

`ifdef FIFO_RD_TIMEOUT_EN
        // T5: burst of 5 with only 2 words aborts on timeout
        base = got_q.size(); p0 = pops; d0 = done_cnt; e0 = err_cnt;
        fifo_push(8'h41);
        fifo_push(8'h42);
        tick();
        send_req(5);
        wait_done(d0, 60, 1'b0);
        tick();
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h42});
        check_beats("t5", base);
        check("t5_pops", pops - p0, 2);
        check("t5_err_once", err_cnt - e0, 1);
        check("t5_err_with_done", pair_err, 0);
        check("t5_busy_low", 32'(busy), 0);
`endif

        // T6: asynchronous reset with the buffer full
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_push(DSIZE'(8'h31 + i));
        tick();
        send_req(6);
        for (int i = 0; i < 4; i++) tick();
        check("t6_buf_full", 32'(dbg_buf_cnt), 2);
        check("t6_rinc_full", 32'(fifo_rinc), 0);
        check("t6_head_data", 32'(m_data), 32'h31);
        check("t6_busy", 32'(busy), 1);
        #2;
        rrst = 1'b1;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 0);
        check("t6_rst_m_data", 32'(m_data), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_req_ready", 32'(req_ready), 1);
        check("t6_rst_rinc", 32'(fifo_rinc), 0);
        check("t6_rst_buf", 32'(dbg_buf_cnt), 0);
        tick();
        rrst = 1'b0;
        m_ready = 1'b1;
        tick();
        base = got_q.size(); p0 = pops; d0 = done_cnt;
        send_req(1);
        wait_done(d0, 40, 1'b0);
        tick();
        exp_q.push_back({1'b1, 8'h33});
        check_beats("t6", base);
        check("t6_pops", pops - p0, 1);
        check("t6_busy_low", 32'(busy), 0);

        check("pop_when_empty", pop_empty, 0);
        check("final_bufcnt_rule", cnt_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
